ram_loader: RTL and testbench
=============================

# ram_loader

Sequential program/data loader that sits directly upstream of the 16x4 RAM on its `csn`/`rwn`/`addr`/`data_in` port. On `start`, it accepts 16 nibbles over a valid/ready stream and writes them to addresses 0..15 in order. While loading, it owns the RAM port; otherwise it passes CPU accesses through unchanged. The block is the boot path that fills RAM before the 4-bit CPU runs.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a load at address 0; sampled only in IDLE or DONE.
- `in_valid` in 1: `in_data` holds a nibble.
- `in_data` in 4: nibble to write.
- `in_ready` out 1: loader accepts a nibble this cycle.
- `cpu_addr` in 4: CPU-side RAM address.
- `cpu_data` in 4: CPU-side RAM write data.
- `cpu_csn` in 1: CPU-side RAM chip select, active-low.
- `cpu_rwn` in 1: CPU-side RAM read/write-not.
- `cpu_gnt` out 1: 1 = CPU owns the RAM port (equals `!busy`).
- `ram_addr` out 4: to RAM `addr`.
- `ram_data_in` out 4: to RAM `data_in`.
- `ram_csn` out 1: to RAM `csn`.
- `ram_rwn` out 1: to RAM `rwn`.
- `ram_data_out` in 4: from RAM `data_out`; used only for verify.
- `busy` out 1: load in progress.
- `done` out 1: last load completed; level, held until the next `start` or `rst`.
- `err` out 1: sticky verify mismatch; constant 0 without verify.

## Operation
- States: IDLE, LOAD, WRITE, VRD, VCHK, DONE. VRD and VCHK exist only with `LOADER_VERIFY_EN`.
- Internal registers:
  - `ptr[3:0]`: next address.
  - `wdata[3:0]`: last accepted nibble.
  - Loader-side `l_addr`, `l_data`, `l_csn`, `l_rwn`.
- Port mux:
  - `busy=1`: `ram_*` = loader registers.
  - `busy=0`: `ram_*` = `cpu_*`, combinational, zero latency.
  - CPU requests while `busy=1` are dropped; the CPU must wait for `cpu_gnt`.
- `busy` = 1 in LOAD, WRITE, VRD, VCHK.
- IDLE/DONE + `start`: `ptr<=0`, `done<=0`, `err<=0`, go to LOAD.
- LOAD: `in_ready=1`. On `in_valid & in_ready`:
  - `l_addr<=ptr`, `l_data<=in_data`, `wdata<=in_data`, `l_csn<=0`, `l_rwn<=0`.
  - Go to WRITE.
  - No transfer: stay in LOAD with `l_csn=1`.
- WRITE: `in_ready=0`. The RAM writes at the end of this cycle. At the edge, `l_csn<=1`, `l_rwn<=1`.
  - Without verify: if `ptr==15`, go to DONE; else `ptr<=ptr+1` and go to LOAD.
  - With verify: `l_csn<=0`, `l_rwn<=1` (read same address), go to VRD.
- VRD: the RAM registers `mem[l_addr]` onto `ram_data_out` at the end of this cycle. Then `l_csn<=1`, go to VCHK.
- VCHK: if `ram_data_out != wdata`, `err<=1`. Then advance exactly as WRITE does without verify.
- DONE: `done=1`, `busy=0`, `in_ready=0`.
- `ptr` increments mod 16 but is never incremented past 15; the load terminates at 15.
- `start` while busy is ignored. There is no abort other than `rst`.
- `in_valid` outside LOAD: no effect; data is not consumed (`in_ready=0`).

## Timing
- Reset values:
  - State IDLE; `ptr=0`, `wdata=0`.
  - `l_addr=0`, `l_data=0`, `l_csn=1`, `l_rwn=1`.
  - `in_ready=0`, `busy=0`, `done=0`, `err=0`, `cpu_gnt=1`.
  - `ram_*` follow `cpu_*`.
- `start` at edge N puts the block in LOAD for cycle N+1, with `in_ready=1` in that cycle.
- Per nibble, with `in_valid` held high:
  - 2 cycles (LOAD, WRITE) without verify.
  - 4 cycles (LOAD, WRITE, VRD, VCHK) with verify.
- Full load with a continuous stream:
  - 32 cycles without verify, 64 with, from first LOAD to DONE entry.
  - `done` rises on the edge after the last WRITE/VCHK.
- The RAM port is handed back to the CPU in the same cycle DONE is entered.
- `rst` mid-load: immediate return to IDLE with reset values. Words already written remain unless the RAM is reset too; on a shared `rst` it is.

## Configuration
- `LOADER_VERIFY_EN` defined:
  - VRD/VCHK states compiled in.
  - Each write is followed by a readback and compare.
  - `err` is sticky until `start` or `rst`.
- Not defined:
  - VRD/VCHK absent.
  - `err` tied to 0.
  - `ram_data_out` unused.

## Test plan
- Reset: assert `rst` mid-cycle. Required immediately and without a clock edge: `busy=0`, `done=0`, `err=0`, `in_ready=0`, `cpu_gnt=1`, and `ram_csn` equals `cpu_csn`.
- Streaming load: `start`, then `in_data`=0..F with `in_valid` held high.
  - `done` after 32 cycles (64 with verify).
  - CPU reads of addr 0..15 then return 0..F.
- Backpressure: `in_valid` toggling 1,0,0,1,… with data A,5,3,….
  - Only handshaked nibbles are written, in address order.
  - `in_ready` never high in WRITE.
- CPU blocked during load: CPU write of `cpu_addr=3`, `cpu_data=F` while `busy=1`.
  - `cpu_gnt=0`; RAM addr 3 keeps the loaded value.
  - After `done`, the CPU write succeeds.
- Verify (macro on): force `ram_data_out` to 0 at address 7 during VCHK while 9 was written.
  - `err=1` and stays 1 through DONE.
  - The next `start` clears `err`.
- Reset mid-load: `rst` after 5 nibbles.
  - Block returns to IDLE.
  - A new `start` plus 16 nibbles completes normally with `done=1`.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader
// Boot-path loader in front of the 16x4 RAM. On start_i it accepts 16
// nibbles over a valid/ready stream and writes them to addresses 0..15 in
// order. While busy_o is high the loader owns the RAM port. At all other
// times the CPU port is passed straight through, combinationally.
//
// Optional feature, selected by the macro LOADER_VERIFY_EN:
//   Each write is followed by a readback and a compare. A mismatch sets the
//   sticky err_o. Without the macro err_o is tied low and ram_data_out_i is
//   unused.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   start_i                  begin a load at address 0 (seen only in IDLE/DONE)
//   in_valid_i, in_data_i    nibble stream in
//   in_ready_o               loader accepts a nibble this cycle
//   cpu_addr_i/_data_i/_csn_i/_rwn_i   CPU-side RAM request
//   cpu_gnt_o                CPU owns the RAM port (= !busy_o)
//   ram_addr_o/_data_in_o/_csn_o/_rwn_o  RAM port
//   ram_data_out_i           RAM read data (used by verify only)
//   busy_o, done_o, err_o    status
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | after reset, CPU owns the RAM
// LOAD   | waiting for a nibble, in_ready_o high
// WRITE  | RAM write of the accepted nibble at ptr
// VRD    | readback of the same address (verify build only)
// VCHK   | compare readback with written nibble (verify build only)
// DONE   | load complete, done_o high, CPU owns the RAM
module ram_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [3:0] in_data_i,
  output logic       in_ready_o,
  input  logic [3:0] cpu_addr_i,
  input  logic [3:0] cpu_data_i,
  input  logic       cpu_csn_i,
  input  logic       cpu_rwn_i,
  output logic       cpu_gnt_o,
  output logic [3:0] ram_addr_o,
  output logic [3:0] ram_data_in_o,
  output logic       ram_csn_o,
  output logic       ram_rwn_o,
  input  logic [3:0] ram_data_out_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef LOADER_VERIFY_EN
    S_VRD   = 3'd4,
    S_VCHK  = 3'd5,
`endif
    S_DONE  = 3'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] wdata_q, wdata_d;
  logic [3:0] l_addr_q, l_addr_d;
  logic [3:0] l_data_q, l_data_d;
  logic       l_csn_q, l_csn_d;
  logic       l_rwn_q, l_rwn_d;
`ifdef LOADER_VERIFY_EN
  logic       err_q, err_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 4'd0;
      wdata_q  <= 4'd0;
      l_addr_q <= 4'd0;
      l_data_q <= 4'd0;
      l_csn_q  <= 1'b1;
      l_rwn_q  <= 1'b1;
`ifdef LOADER_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wdata_q  <= wdata_d;
      l_addr_q <= l_addr_d;
      l_data_q <= l_data_d;
      l_csn_q  <= l_csn_d;
      l_rwn_q  <= l_rwn_d;
`ifdef LOADER_VERIFY_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wdata_d  = wdata_q;
    l_addr_d = l_addr_q;
    l_data_d = l_data_q;
    l_csn_d  = l_csn_q;
    l_rwn_d  = l_rwn_q;
`ifdef LOADER_VERIFY_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          ptr_d   = 4'd0;
`ifdef LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        l_csn_d = 1'b1;
        if (in_valid_i) begin
          l_addr_d = ptr_q;
          l_data_d = in_data_i;
          wdata_d  = in_data_i;
          l_csn_d  = 1'b0;
          l_rwn_d  = 1'b0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef LOADER_VERIFY_EN
        // Turn the write into a read of the same address.
        l_csn_d = 1'b0;
        l_rwn_d = 1'b1;
        state_d = S_VRD;
`else
        l_csn_d = 1'b1;
        l_rwn_d = 1'b1;
        if (ptr_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + 4'd1;
          state_d = S_LOAD;
        end
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VRD: begin
        l_csn_d = 1'b1;
        state_d = S_VCHK;
      end
      S_VCHK: begin
        if (ram_data_out_i != wdata_q) begin
          err_d = 1'b1;
        end
        if (ptr_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + 4'd1;
          state_d = S_LOAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_WRITE: busy_o = 1'b1;
`ifdef LOADER_VERIFY_EN
      S_VRD:   busy_o = 1'b1;
      S_VCHK:  busy_o = 1'b1;
`endif
      S_DONE:  done_o = 1'b1;
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  assign cpu_gnt_o = ~busy_o;

  // RAM port mux: the CPU path has no register stage.
  assign ram_addr_o    = busy_o ? l_addr_q : cpu_addr_i;
  assign ram_data_in_o = busy_o ? l_data_q : cpu_data_i;
  assign ram_csn_o     = busy_o ? l_csn_q  : cpu_csn_i;
  assign ram_rwn_o     = busy_o ? l_rwn_q  : cpu_rwn_i;

`ifdef LOADER_VERIFY_EN
  assign err_o = err_q;
`else
  // Readback data and the last nibble only matter to the verify path.
  logic unused_verify;
  assign unused_verify = ^{ram_data_out_i, wdata_q};
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

`ifdef LOADER_VERIFY_EN
  localparam int EXP_CYC = 64;
`else
  localparam int EXP_CYC = 32;
`endif

  logic       clk, rst;
  logic       start, in_valid, in_ready;
  logic [3:0] in_data;
  logic [3:0] cpu_addr, cpu_data;
  logic       cpu_csn, cpu_rwn, cpu_gnt;
  logic [3:0] ram_addr, ram_data_in, ram_data_out;
  logic       ram_csn, ram_rwn;
  logic       busy, done, err;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  // 16x4 RAM model; shares rst with the loader.
  logic [3:0] mem [16];
  bit         corrupt_en = 0;

  ram_loader dut (
    .clk(clk), .rst(rst),
    .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data), .cpu_csn_i(cpu_csn), .cpu_rwn_i(cpu_rwn),
    .cpu_gnt_o(cpu_gnt),
    .ram_addr_o(ram_addr), .ram_data_in_o(ram_data_in), .ram_csn_o(ram_csn), .ram_rwn_o(ram_rwn),
    .ram_data_out_i(ram_data_out),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
      ram_data_out <= 4'h0;
    end else if (!ram_csn) begin
      if (!ram_rwn) mem[ram_addr] <= ram_data_in;
      else if (corrupt_en && ram_addr == 4'd7) ram_data_out <= 4'h0;
      else ram_data_out <= mem[ram_addr];
    end
  end

  task automatic cpu_read(input logic [3:0] a, output logic [3:0] d);
    cpu_addr = a; cpu_rwn = 1; cpu_csn = 0;
    @(posedge clk); #1;
    d = ram_data_out;
    cpu_csn = 1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [3:0] d);
    cpu_addr = a; cpu_data = d; cpu_rwn = 0; cpu_csn = 0;
    @(posedge clk); #1;
    cpu_csn = 1; cpu_rwn = 1;
  endtask

  // Pops one expected nibble per address and compares with a CPU read.
  task automatic check_readback(input string name);
    logic [3:0] got, want;
    for (int a = 0; a < 16; a++) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s addr %0d: no expected value queued", name, a);
      end else begin
        want = exp_q.pop_front();
        cpu_read(a[3:0], got);
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s addr %0d: got %h want %h", name, a, got, want);
        end
      end
    end
  endtask

  // One full load. gaps selects the 1,0,0,1 valid pattern; cpu_block keeps
  // a CPU write to address 3 asserted while the loader is busy.
  task automatic run_load(input logic [3:0] d[16], input bit gaps, input bit cpu_block,
                          input bit exp_err, input string name);
    int  idx = 0, k = 0, cyc = 0;
    bit  prev_hs = 0, hs, gnt_checked = 0;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_load: in_ready %b busy %b want 1 1", name, in_ready, busy);
    end
    if (cpu_block) begin
      cpu_addr = 4'd3; cpu_data = 4'hF; cpu_rwn = 0; cpu_csn = 0;
    end
    while (!done && cyc < 300) begin
      in_valid = gaps ? pat[k % 4] : 1'b1;
      in_data  = in_valid ? d[idx[3:0]] : ~d[idx[3:0]];
      k++;
      @(negedge clk);
      if (prev_hs) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s in_ready_in_write: got %b want 0", name, in_ready);
        end
      end
      if (cpu_block && busy && !gnt_checked) begin
        gnt_checked = 1;
        n_vec++;
        if (cpu_gnt !== 1'b0) begin
          n_bad++;
          $display("FAIL %s cpu_gnt_busy: got %b want 0", name, cpu_gnt);
        end
      end
      hs = in_valid && in_ready;
      if (hs) begin
        exp_q.push_back(d[idx[3:0]]);
        idx++;
      end
      prev_hs = hs;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    cpu_csn = 1; cpu_rwn = 1;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done_state: done %b busy %b gnt %b want 1 0 1 (cyc %0d)",
               name, done, busy, cpu_gnt, cyc);
    end
    n_vec++;
    if (idx != 16) begin
      n_bad++;
      $display("FAIL %s accepted: got %0d nibbles want 16", name, idx);
    end
    if (!gaps) begin
      n_vec++;
      if (cyc != EXP_CYC) begin
        n_bad++;
        $display("FAIL %s load_cycles: got %0d want %0d", name, cyc, EXP_CYC);
      end
    end
    n_vec++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    #2;
    rst = 0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [3:0] d[16];
    for (int i = 0; i < 16; i++) d[i] = 4'(i);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1; in_data = 4'h6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    rst = 1;
    cpu_csn = 0;
    #1;
    n_vec++;
    if (busy !== 0 || done !== 0 || err !== 0 || in_ready !== 0 || cpu_gnt !== 1) begin
      n_bad++;
      $display("FAIL reset_outputs: busy %b done %b err %b rdy %b gnt %b want 0 0 0 0 1",
               busy, done, err, in_ready, cpu_gnt);
    end
    n_vec++;
    if (ram_csn !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_csn_pass0: got %b want 0", ram_csn);
    end
    cpu_csn = 1;
    #1;
    n_vec++;
    if (ram_csn !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_csn_pass1: got %b want 1", ram_csn);
    end
    in_valid = 0;
    rst = 0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [3:0] d[16];
    for (int i = 0; i < 16; i++) d[i] = 4'(i);
    run_load(d, 0, 0, 0, "stream");
    check_readback("stream_rd");
  endtask

  task automatic test_backpressure();
    logic [3:0] d[16] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h1, 4'hE, 4'h7, 4'h0,
                          4'h9, 4'h2, 4'hB, 4'h4, 4'hF, 4'h6, 4'hD, 4'h8};
    run_load(d, 1, 0, 0, "bp");
    check_readback("bp_rd");
  endtask

  task automatic test_cpu_blocked();
    logic [3:0] d[16];
    logic [3:0] got;
    for (int i = 0; i < 16; i++) d[i] = 4'(15 - i);
    run_load(d, 0, 1, 0, "blk");
    check_readback("blk_rd");
    cpu_write(4'd3, 4'hF);
    cpu_read(4'd3, got);
    n_vec++;
    if (got !== 4'hF) begin
      n_bad++;
      $display("FAIL blk_cpu_write_after_done: got %h want F", got);
    end
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    logic [3:0] d[16];
    for (int i = 0; i < 16; i++) d[i] = 4'(i);
    d[7] = 4'h9;
    corrupt_en = 1;
    run_load(d, 0, 0, 1, "verify");
    corrupt_en = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (err !== 1'b1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL verify_sticky: err %b done %b want 1 1", err, done);
    end
    check_readback("verify_rd");
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL verify_clear_on_start: got %b want 0", err);
    end
    pulse_reset();
  endtask
`endif

  task automatic test_reset_mid_load();
    logic [3:0] d[16];
    int n = 0, cyc = 0;
    for (int i = 0; i < 16; i++) d[i] = 4'(i ^ 5);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    while (n < 5 && cyc < 100) begin
      in_data = 4'hE;
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    #3;
    rst = 1;
    #1;
    n_vec++;
    if (busy !== 0 || in_ready !== 0 || done !== 0 || cpu_gnt !== 1 || n != 5) begin
      n_bad++;
      $display("FAIL rml_idle: busy %b rdy %b done %b gnt %b nibbles %0d want 0 0 0 1 5",
               busy, in_ready, done, cpu_gnt, n);
    end
    rst = 0;
    exp_q.delete();
    @(posedge clk); #1;
    run_load(d, 0, 0, 0, "rml_reload");
    check_readback("rml_rd");
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = 0;
    cpu_addr = 0; cpu_data = 0; cpu_csn = 1; cpu_rwn = 1;
    #12;
    rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_cpu_blocked();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
